// File: rtl/tetris_pkg.sv
// Shared types for the input action scheduler:
// action codes, FSM states and the pending-source bundle.
package tetris_pkg;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_LEFT  = 3'd1,
    ACT_RIGHT = 3'd2,
    ACT_ROT   = 3'd3,
    ACT_DROP  = 3'd4,
    ACT_GRAV  = 3'd5
  } act_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  typedef struct packed {
    logic grav;
    logic drop;
    logic rot;
    logic left;
    logic right;
  } pend_t;

  // Fixed priority: GRAV > DROP > ROT > LEFT > RIGHT
  function automatic act_e pick_act(pend_t p);
    act_e a;
    a = ACT_NONE;
    if (p.grav)       a = ACT_GRAV;
    else if (p.drop)  a = ACT_DROP;
    else if (p.rot)   a = ACT_ROT;
    else if (p.left)  a = ACT_LEFT;
    else if (p.right) a = ACT_RIGHT;
    return a;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Input-frame timer: divides the system clock down to one
// registered single-cycle enable per input frame.
module frame_tick_gen #(
  parameter int CLK_HZ   = 50000000,
  parameter int INPUT_HZ = 60
) (
  input  logic clock,
  input  logic resetn,
  output logic tick_input
);

  localparam int DIV_RAW = CLK_HZ / INPUT_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      r_tick <= w_wrap;
    end
  end

  assign tick_input = r_tick;

endmodule

// File: rtl/input_action_scheduler.sv
// Coalesces button and gravity requests into pending bits and
// offers one action at a time to the game engine.
module input_action_scheduler
  import tetris_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int INPUT_HZ    = 60,
  parameter int GRAV_FRAMES = 48
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rot,
  input  logic       btn_drop,
  input  logic       pause,
  input  logic       act_ready,
  input  logic       act_done,
  output logic       tick_input,
  output logic       act_valid,
  output logic [2:0] act_code,
  output logic       busy
);

  localparam logic [7:0] GLAST = 8'(GRAV_FRAMES - 1);

  logic       w_tick;
  state_e     r_state;
  state_e     w_state_nx;
  act_e       r_code;
  act_e       w_code_nx;
  act_e       w_win;
  pend_t      r_pend;
  pend_t      w_set;
  pend_t      w_clr;
  pend_t      w_cand;
  logic [7:0] r_gcnt;
  logic       w_grav_wrap;
  logic       w_drop_acc;
  logic       w_arb;
  logic       w_lr;

  frame_tick_gen #(
    .CLK_HZ   (CLK_HZ),
    .INPUT_HZ (INPUT_HZ)
  ) u_tick (
    .clock      (clock),
    .resetn     (resetn),
    .tick_input (w_tick)
  );

  assign tick_input = w_tick;

  assign w_grav_wrap = w_tick & ~pause & (r_gcnt == GLAST);
  assign w_drop_acc  = (r_state == ST_OFFER) & act_ready
                     & (r_code == ACT_DROP);
  assign w_arb       = (r_state == ST_IDLE) & ~pause & (|r_pend);
  assign w_lr        = r_pend.left & r_pend.right;

  // Opposing moves cancel each other out of arbitration
  always_comb begin
    w_cand = r_pend;
    if (w_lr) begin
      w_cand.left  = 1'b0;
      w_cand.right = 1'b0;
    end
  end

  assign w_win = pick_act(w_cand);

  always_comb begin
    w_set       = '0;
    w_set.grav  = w_grav_wrap;
    w_set.drop  = btn_drop;
    w_set.rot   = btn_rot;
    w_set.left  = btn_left;
    w_set.right = btn_right;
  end

  always_comb begin
    w_clr = '0;
    if (w_arb) begin
      w_clr.left  = w_lr;
      w_clr.right = w_lr;
      unique case (w_win)
        ACT_GRAV:  w_clr.grav  = 1'b1;
        ACT_DROP:  w_clr.drop  = 1'b1;
        ACT_ROT:   w_clr.rot   = 1'b1;
        ACT_LEFT:  w_clr.left  = 1'b1;
        ACT_RIGHT: w_clr.right = 1'b1;
        default: ;
      endcase
    end
    if (w_drop_acc) w_clr.grav = 1'b1;
  end

  // Set is OR-ed in last so a same-cycle set survives a clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pend <= '0;
    end else begin
      r_pend <= pend_t'((r_pend & ~w_clr) | w_set);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_gcnt <= '0;
    end else if (w_drop_acc) begin
      r_gcnt <= '0;
    end else if (w_tick && !pause) begin
      r_gcnt <= (r_gcnt == GLAST) ? 8'd0 : r_gcnt + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_code  <= ACT_NONE;
    end else begin
      r_state <= w_state_nx;
      r_code  <= w_code_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_code_nx  = r_code;
    unique case (r_state)
      ST_IDLE: begin
        if (w_arb && w_win != ACT_NONE) begin
          w_state_nx = ST_OFFER;
          w_code_nx  = w_win;
        end
      end
      ST_OFFER: begin
        if (act_ready) w_state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (act_done) begin
          w_state_nx = ST_IDLE;
          w_code_nx  = ACT_NONE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_code_nx  = ACT_NONE;
      end
    endcase
  end

  assign act_valid = (r_state == ST_OFFER);
  assign busy      = (r_state == ST_WAIT);
  assign act_code  = (r_state == ST_IDLE) ? 3'd0 : r_code;

endmodule

// File: tb/tb_input_action_scheduler.sv
// Bench for input_action_scheduler: directed scenarios plus
// random stimulus against a cycle-level behavioural model.
module tb_input_action_scheduler;

  localparam int CLK_HZ = 600;
  localparam int IN_HZ  = 60;
  localparam int GF     = 3;
  localparam int DIV    = CLK_HZ / IN_HZ;

  logic       clock;
  logic       resetn;
  logic       btn_left;
  logic       btn_right;
  logic       btn_rot;
  logic       btn_drop;
  logic       pause;
  logic       act_ready;
  logic       act_done;
  logic       tick_input;
  logic       act_valid;
  logic [2:0] act_code;
  logic       busy;

  input_action_scheduler #(
    .CLK_HZ      (CLK_HZ),
    .INPUT_HZ    (IN_HZ),
    .GRAV_FRAMES (GF)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .btn_rot    (btn_rot),
    .btn_drop   (btn_drop),
    .pause      (pause),
    .act_ready  (act_ready),
    .act_done   (act_done),
    .tick_input (tick_input),
    .act_valid  (act_valid),
    .act_code   (act_code),
    .busy       (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;

  // model: mode 0 idle, 1 offering, 2 engine busy
  int m_fcnt;
  int m_gcnt;
  int m_mode;
  int m_code;
  bit m_tick;
  bit m_pend [1:5];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_fcnt = 0;
    m_gcnt = 0;
    m_mode = 0;
    m_code = 0;
    m_tick = 0;
    for (int k = 1; k <= 5; k++) m_pend[k] = 0;
  endtask

  task automatic m_step(input bit bl, input bit br,
                        input bit brt, input bit bd,
                        input bit pz, input bit rdy,
                        input bit dn);
    bit clr [1:5];
    bit st [1:5];
    int order [5] = '{5, 4, 3, 1, 2};
    bit lr;
    bit any;
    bit dacc;
    int win;
    for (int k = 1; k <= 5; k++) begin
      clr[k] = 0;
      st[k]  = 0;
    end
    lr  = m_pend[1] && m_pend[2];
    any = 0;
    for (int k = 1; k <= 5; k++) any |= m_pend[k];
    win = 0;
    if (m_mode == 0 && !pz && any) begin
      if (lr) begin
        clr[1] = 1;
        clr[2] = 1;
      end
      foreach (order[j]) begin
        if (win == 0 && m_pend[order[j]] &&
            !(lr && order[j] <= 2))
          win = order[j];
      end
      if (win != 0) clr[win] = 1;
    end
    dacc = (m_mode == 1) && rdy && (m_code == 4);
    if (dacc) clr[5] = 1;
    st[1] = bl;
    st[2] = br;
    st[3] = brt;
    st[4] = bd;
    st[5] = m_tick && !pz && (m_gcnt == GF - 1);
    if (dacc) m_gcnt = 0;
    else if (m_tick && !pz) m_gcnt = (m_gcnt + 1) % GF;
    m_tick = (m_fcnt == DIV - 1);
    m_fcnt = (m_fcnt + 1) % DIV;
    for (int k = 1; k <= 5; k++)
      m_pend[k] = (m_pend[k] && !clr[k]) || st[k];
    case (m_mode)
      0: if (win != 0) begin
        m_mode = 1;
        m_code = win;
      end
      1: if (rdy) m_mode = 2;
      default: if (dn) m_mode = 0;
    endcase
  endtask

  // Called at a falling edge: check, drive, advance model.
  task automatic cyc(input bit bl, input bit br,
                     input bit brt, input bit bd,
                     input bit pz, input bit rdy,
                     input bit dn);
    chk("tick", tick_input, m_tick);
    chk("valid", act_valid, m_mode == 1);
    chk("busy", busy, m_mode == 2);
    chk("code", act_code, (m_mode == 0) ? 0 : m_code);
    btn_left  = bl;
    btn_right = br;
    btn_rot   = brt;
    btn_drop  = bd;
    pause     = pz;
    act_ready = rdy;
    act_done  = dn;
    m_step(bl, br, brt, bd, pz, rdy, dn);
    @(negedge clock);
  endtask

  task automatic do_reset();
    btn_left  = 0;
    btn_right = 0;
    btn_rot   = 0;
    btn_drop  = 0;
    pause     = 0;
    act_ready = 0;
    act_done  = 0;
    resetn    = 0;
    #1;
    chk("rst_valid", act_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_code", act_code, 0);
    chk("rst_tick", tick_input, 0);
    m_reset();
    @(negedge clock);
    resetn = 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    int nv;
    int nl;
    bit pz;
    resetn    = 0;
    btn_left  = 0;
    btn_right = 0;
    btn_rot   = 0;
    btn_drop  = 0;
    pause     = 0;
    act_ready = 0;
    act_done  = 0;
    m_reset();
    @(negedge clock);

    // tick cadence and first gravity action
    do_reset();
    for (int c = 0; c < 33; c++) begin
      if (c == 9)  chk("pre_tick", tick_input, 0);
      if (c == 10) chk("first_tick", tick_input, 1);
      if (c == 20) chk("second_tick", tick_input, 1);
      if (c == 31) chk("grav_early", act_valid, 0);
      if (c == 32) begin
        chk("grav_valid", act_valid, 1);
        chk("grav_code", act_code, 5);
      end
      cyc(0, 0, 0, 0, 0, 0, 0);
    end

    // rotate beats left, left follows
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c == 2) chk("rot_first", act_code, 3);
      if (c == 3) chk("rot_busy", busy, 1);
      if (c == 5) chk("left_next", act_code, 1);
      cyc(c == 0, 0, c == 0, 0, 0, 1, c == 3);
    end

    // left and right cancel
    do_reset();
    nv = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8 && act_valid) nv++;
      if (c == 8) chk("rot_after_lr", act_code, 3);
      if (c == 12) chk("lr_gone", act_valid, 0);
      cyc(c == 0, c == 0, c == 6, 0, 0, 1, c == 9);
    end
    chk("lr_no_action", nv, 0);

    // drop restarts gravity
    do_reset();
    for (int c = 0; c < 53; c++) begin
      if (c == 23) chk("drop_code", act_code, 4);
      if (c == 32) chk("grav_deferred", act_valid, 0);
      if (c == 52) chk("grav_after_drop", act_code, 5);
      cyc(0, 0, 0, c == 21, 0, c == 23, c == 25);
    end

    // pause holds issue, pulses coalesce
    do_reset();
    nv = 0;
    for (int c = 0; c < 100; c++) begin
      if (act_valid) nv++;
      cyc(c % 7 == 3, 0, 0, 0, 1, 1, 0);
    end
    chk("pause_no_valid", nv, 0);
    nl = 0;
    for (int c = 0; c < 15; c++) begin
      if (act_valid && act_code == 3'd1) nl++;
      cyc(0, 0, 0, 0, 0, 1, m_mode == 2);
    end
    chk("pause_one_left", nl, 1);

    // reset while busy abandons the action
    do_reset();
    for (int c = 0; c < 4; c++) cyc(0, 0, c == 0, 0, 0, 1, 0);
    chk("pre_rst_busy", busy, 1);
    do_reset();
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      if (act_valid) nv++;
      cyc(0, 0, 0, 0, 0, 1, c == 0);
    end
    chk("no_reissue", nv, 0);

    // random traffic
    do_reset();
    pz = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        pz = 0;
      end else begin
        if ($urandom_range(0, 39) == 0) pz = !pz;
        cyc($urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 19) == 0,
            pz,
            $urandom_range(0, 1) == 1,
            (m_mode == 2) ? ($urandom_range(0, 2) == 0)
                          : ($urandom_range(0, 19) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
